ahb3lite_host_master: RTL

AHB3LITE_HOST_MASTER -- requirements
Module: ahb3lite_host_master

---
 rtl/ahb3lite_host_master.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/ahb3lite_host_master.sv
// Single-transfer AHB3-lite master behind a valid/ready request/response pair.
// Optional AHB3LITE_HOST_MASTER_ALIGN_CHECK_EN rejects misaligned halfword/word requests locally.
module ahb3lite_host_master #(
  parameter logic [3:0] HPROT_VAL = 4'b0011
) (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_size,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] HADDR,
  output logic [31:0] HWDATA,
  output logic [1:0]  HTRANS,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic        HWRITE,
  output logic        HMASTLOCK,
  input  logic [31:0] HRDATA,
  input  logic        HRESP,
  input  logic        HREADY
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_DATA = 2'b10,
    ST_RESP = 2'b11
  } state_t;

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;

  state_t      state_r, state_nxt;
  logic [31:0] haddr_r, haddr_nxt;
  logic [31:0] hwdata_r, hwdata_nxt;
  logic [1:0]  htrans_r, htrans_nxt;
  logic [2:0]  hsize_r, hsize_nxt;
  logic        hwrite_r, hwrite_nxt;
  logic [31:0] wdata_r, wdata_nxt;
  logic [31:0] rdata_r, rdata_nxt;
  logic        err_r, err_nxt;
  logic        req_ready_r;
  logic        rsp_valid_r;
  logic        req_bad_s;

`ifdef AHB3LITE_HOST_MASTER_ALIGN_CHECK_EN
  function automatic logic misaligned(input logic [2:0] size, input logic [1:0] addr_lsb);
    logic bad;
    case (size)
      3'd1:    bad = addr_lsb[0];
      3'd2:    bad = (addr_lsb != 2'b00);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction
`endif

  // Requests that complete locally with an error and never reach the bus
  always_comb begin
    req_bad_s = 1'b0;
    if (req_size > 3'd2) begin
      req_bad_s = 1'b1;
    end
`ifdef AHB3LITE_HOST_MASTER_ALIGN_CHECK_EN
    else if (misaligned(req_size, req_addr[1:0])) begin
      req_bad_s = 1'b1;
    end
`endif
    else begin
      req_bad_s = 1'b0;
    end
  end

  // Next state and next values of every registered output
  always_comb begin
    state_nxt  = state_r;
    haddr_nxt  = haddr_r;
    hwdata_nxt = hwdata_r;
    htrans_nxt = TRANS_IDLE;
    hsize_nxt  = hsize_r;
    hwrite_nxt = hwrite_r;
    wdata_nxt  = wdata_r;
    rdata_nxt  = rdata_r;
    err_nxt    = err_r;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          wdata_nxt = req_wdata;
          if (req_bad_s) begin
            state_nxt = ST_RESP;
            rdata_nxt = 32'h0000_0000;
            err_nxt   = 1'b1;
          end else begin
            state_nxt  = ST_ADDR;
            htrans_nxt = TRANS_NONSEQ;
            haddr_nxt  = req_addr;
            hsize_nxt  = req_size;
            hwrite_nxt = req_write;
          end
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (HREADY) begin
          state_nxt  = ST_DATA;
          htrans_nxt = TRANS_IDLE;
          if (hwrite_r) begin
            hwdata_nxt = wdata_r;
          end else begin
            hwdata_nxt = hwdata_r;
          end
        end else begin
          htrans_nxt = TRANS_NONSEQ;
        end
      end
      ST_DATA: begin
        // The first error cycle has HREADY low and is simply waited out
        if (HREADY) begin
          state_nxt = ST_RESP;
          err_nxt   = HRESP;
          if (hwrite_r) begin
            rdata_nxt = 32'h0000_0000;
          end else begin
            rdata_nxt = HRDATA;
          end
        end else begin
          state_nxt = ST_DATA;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_RESP;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register and registered outputs, synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      state_r     <= ST_IDLE;
      haddr_r     <= 32'h0000_0000;
      hwdata_r    <= 32'h0000_0000;
      htrans_r    <= TRANS_IDLE;
      hsize_r     <= 3'b000;
      hwrite_r    <= 1'b0;
      wdata_r     <= 32'h0000_0000;
      rdata_r     <= 32'h0000_0000;
      err_r       <= 1'b0;
      req_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt;
      haddr_r     <= haddr_nxt;
      hwdata_r    <= hwdata_nxt;
      htrans_r    <= htrans_nxt;
      hsize_r     <= hsize_nxt;
      hwrite_r    <= hwrite_nxt;
      wdata_r     <= wdata_nxt;
      rdata_r     <= rdata_nxt;
      err_r       <= err_nxt;
      req_ready_r <= (state_nxt == ST_IDLE);
      rsp_valid_r <= (state_nxt == ST_RESP);
    end
  end

  assign req_ready = req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rdata_r;
  assign rsp_err   = err_r;
  assign HADDR     = haddr_r;
  assign HWDATA    = hwdata_r;
  assign HTRANS    = htrans_r;
  assign HSIZE     = hsize_r;
  assign HWRITE    = hwrite_r;
  assign HBURST    = 3'b000;
  assign HPROT     = HPROT_VAL;
  assign HMASTLOCK = 1'b0;

endmodule
